// File: rtl/seg_capture_decoder.sv
// -----------------------------------------------------------------------------
// seg_capture_decoder
// Monitors a multiplexed, active-low seven-segment display bus and recovers the
// hex nibble shown on each digit. Each digit dwell is debounced, then the
// segment pattern is decoded back to hex. The result goes into one nibble
// register per digit. Blank (all-off) and illegal patterns are flagged per digit.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   seg_n[6:0]   segment bus {a,b,c,d,e,f,g}, a is MSB, active-low
//   an_n[N-1:0]  digit enables, active-low, bit i selects digit i
//   clr          synchronous clear of all captured state (same effect as rst)
//   hex_out      captured nibbles, digit i in bits [4i+3:4i]
//   digit_valid  digit i holds a successfully decoded nibble
//   digit_blank  last capture for digit i was all-off
//   digit_err    last capture for digit i was an illegal pattern
//   upd          one-cycle pulse on every capture
//   upd_idx      digit index of the capture, valid while upd=1
// -----------------------------------------------------------------------------
module seg_capture_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   an_n,
    input  logic                    clr,
    output logic [4*NUM_DIGITS-1:0] hex_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [NUM_DIGITS-1:0]   digit_blank,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    upd,
    output logic [2:0]              upd_idx
);

    localparam int SW = NUM_DIGITS + 7;
    localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // Returns {legal, nibble}; only exact matches of the encoder's glyphs are legal.
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        case (s)
            7'b0000001: seg_decode = {1'b1, 4'h0};
            7'b1001111: seg_decode = {1'b1, 4'h1};
            7'b0010010: seg_decode = {1'b1, 4'h2};
            7'b0000110: seg_decode = {1'b1, 4'h3};
            7'b1001100: seg_decode = {1'b1, 4'h4};
            7'b0100100: seg_decode = {1'b1, 4'h5};
            7'b0100000: seg_decode = {1'b1, 4'h6};
            7'b0001111: seg_decode = {1'b1, 4'h7};
            7'b0000000: seg_decode = {1'b1, 4'h8};
            7'b0001100: seg_decode = {1'b1, 4'h9};
            7'b0001000: seg_decode = {1'b1, 4'hA};
            7'b1100000: seg_decode = {1'b1, 4'hB};
            7'b0110001: seg_decode = {1'b1, 4'hC};
            7'b1000010: seg_decode = {1'b1, 4'hD};
            7'b0110000: seg_decode = {1'b1, 4'hE};
            7'b0111000: seg_decode = {1'b1, 4'hF};
            default:    seg_decode = {1'b0, 4'h0};
        endcase
    endfunction

    // Exactly one enable asserted (one zero in the active-low vector).
    function automatic logic is_single(input logic [NUM_DIGITS-1:0] an);
        logic [NUM_DIGITS-1:0] sel;
        sel       = ~an;
        is_single = (sel != '0) && ((sel & (sel - NUM_DIGITS'(1))) == '0);
    endfunction

    logic [SW-1:0]           smp_q, smp_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    state_t                  state_q, state_d;
    logic [4*NUM_DIGITS-1:0] hex_q, hex_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
    logic [NUM_DIGITS-1:0]   err_q, err_d;
    logic                    upd_q, upd_d;
    logic [2:0]              upd_idx_q, upd_idx_d;

    logic                    chg_s;
    logic                    new_single_s;
    logic                    capture_s;
    logic [2:0]              sel_idx_s;
    logic [4:0]              dec_s;

    // Input sample and stability counter: restart on any change, saturate otherwise.
    always_comb begin
        smp_d        = {an_n, seg_n};
        chg_s        = (smp_d != smp_q);
        new_single_s = is_single(smp_d[SW-1:7]);
        if (chg_s) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Index of the selected digit in the held sample (meaningful only when single).
    always_comb begin
        sel_idx_s = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!smp_q[7+i]) begin
                sel_idx_s = 3'(i);
            end else begin
                sel_idx_s = sel_idx_s;
            end
        end
    end

    // Dwell FSM. Capture fires on the edge where the counter reaches its final
    // count with the sample unchanged, so the capture lands STABLE_CYCLES-1
    // edges after the first sample of the dwell.
    always_comb begin
        state_d   = state_q;
        capture_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (new_single_s) begin
                    state_d = SETTLE;
                end else begin
                    state_d = IDLE;
                end
            end
            SETTLE: begin
                if (chg_s) begin
                    state_d = new_single_s ? SETTLE : IDLE;
                end else if (cnt_d == CNT_MAX) begin
                    capture_s = 1'b1;
                    state_d   = HOLD;
                end else begin
                    state_d = SETTLE;
                end
            end
            HOLD: begin
                if (chg_s) begin
                    state_d = new_single_s ? SETTLE : IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Per-digit capture effect; only the selected digit is touched.
    always_comb begin
        dec_s     = seg_decode(smp_q[6:0]);
        hex_d     = hex_q;
        valid_d   = valid_q;
        blank_d   = blank_q;
        err_d     = err_q;
        upd_d     = capture_s;
        upd_idx_d = capture_s ? sel_idx_s : 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (capture_s && (sel_idx_s == 3'(i))) begin
                if (dec_s[4]) begin
                    hex_d[4*i +: 4] = dec_s[3:0];
                    valid_d[i]      = 1'b1;
                    blank_d[i]      = 1'b0;
                    err_d[i]        = 1'b0;
                end else if (smp_q[6:0] == 7'b1111111) begin
                    valid_d[i] = 1'b0;
                    blank_d[i] = 1'b1;
                    err_d[i]   = 1'b0;
                end else begin
                    valid_d[i] = 1'b0;
                    blank_d[i] = 1'b0;
                    err_d[i]   = 1'b1;
                end
            end else begin
                hex_d[4*i +: 4] = hex_q[4*i +: 4];
            end
        end
    end

    // State and output registers; rst and clr have identical effect.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            smp_q     <= '1;
            cnt_q     <= '0;
            state_q   <= IDLE;
            hex_q     <= '0;
            valid_q   <= '0;
            blank_q   <= '0;
            err_q     <= '0;
            upd_q     <= 1'b0;
            upd_idx_q <= 3'd0;
        end else begin
            smp_q     <= smp_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            hex_q     <= hex_d;
            valid_q   <= valid_d;
            blank_q   <= blank_d;
            err_q     <= err_d;
            upd_q     <= upd_d;
            upd_idx_q <= upd_idx_d;
        end
    end

    assign hex_out     = hex_q;
    assign digit_valid = valid_q;
    assign digit_blank = blank_q;
    assign digit_err   = err_q;
    assign upd         = upd_q;
    assign upd_idx     = upd_idx_q;

endmodule

// File: tb/tb_seg_capture_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg_capture_decoder
// Directed scenarios followed by random dwells, all compared every cycle
// against a dwell-level reference model: a pattern is captured once it has
// been seen STABLE_CYCLES consecutive samples with exactly one digit selected,
// and not again until the pattern changes.
// -----------------------------------------------------------------------------
module tb_seg_capture_decoder;

    localparam int ND = 4;
    localparam int SC = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            clr;
    logic [6:0]      seg_n;
    logic [ND-1:0]   an_n;
    logic [4*ND-1:0] hex_out;
    logic [ND-1:0]   digit_valid;
    logic [ND-1:0]   digit_blank;
    logic [ND-1:0]   digit_err;
    logic            upd;
    logic [2:0]      upd_idx;

    seg_capture_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_n       (seg_n),
        .an_n        (an_n),
        .clr         (clr),
        .hex_out     (hex_out),
        .digit_valid (digit_valid),
        .digit_blank (digit_blank),
        .digit_err   (digit_err),
        .upd         (upd),
        .upd_idx     (upd_idx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int upd_seen = 0;

    logic [6:0] pat [16];

    // Reference model state
    logic [ND+6:0]   m_prev;
    int              m_run;
    bit              m_done;
    logic [4*ND-1:0] m_hex;
    logic [ND-1:0]   m_valid, m_blank, m_err;
    logic            m_upd;
    logic [2:0]      m_idx;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev  = '1;
        m_run   = 0;
        m_done  = 0;
        m_hex   = '0;
        m_valid = '0;
        m_blank = '0;
        m_err   = '0;
        m_upd   = 1'b0;
        m_idx   = 3'd0;
    endtask

    task automatic model_edge();
        logic [ND+6:0] x;
        int            zeros;
        int            pos;
        int            nib;
        x     = {an_n, seg_n};
        m_upd = 1'b0;
        if (rst || clr) begin
            model_reset();
        end else begin
            if (x != m_prev) begin
                m_prev = x;
                m_run  = 1;
                m_done = 0;
            end else begin
                m_run++;
            end
            zeros = 0;
            pos   = 0;
            for (int k = 0; k < ND; k++) begin
                if (an_n[k] == 1'b0) begin
                    zeros++;
                    pos = k;
                end
            end
            if (m_run >= SC && !m_done && zeros == 1) begin
                m_done = 1;
                m_upd  = 1'b1;
                m_idx  = 3'(pos);
                nib    = -1;
                for (int k = 0; k < 16; k++) begin
                    if (pat[k] == seg_n) nib = k;
                end
                if (nib >= 0) begin
                    m_hex[4*pos +: 4] = 4'(nib);
                    m_valid[pos] = 1'b1;
                    m_blank[pos] = 1'b0;
                    m_err[pos]   = 1'b0;
                end else if (seg_n == 7'b1111111) begin
                    m_valid[pos] = 1'b0;
                    m_blank[pos] = 1'b1;
                    m_err[pos]   = 1'b0;
                end else begin
                    m_valid[pos] = 1'b0;
                    m_blank[pos] = 1'b0;
                    m_err[pos]   = 1'b1;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("hex_out", hex_out, m_hex);
        check("digit_valid", digit_valid, m_valid);
        check("digit_blank", digit_blank, m_blank);
        check("digit_err", digit_err, m_err);
        check("upd", upd, m_upd);
        if (m_upd) check("upd_idx", upd_idx, m_idx);
        if (upd === 1'b1) upd_seen++;
    endtask

    task automatic apply(input logic [ND-1:0] an, input logic [6:0] seg, input int n);
        an_n  = an;
        seg_n = seg;
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        pat[0]  = 7'b0000001; pat[1]  = 7'b1001111; pat[2]  = 7'b0010010; pat[3]  = 7'b0000110;
        pat[4]  = 7'b1001100; pat[5]  = 7'b0100100; pat[6]  = 7'b0100000; pat[7]  = 7'b0001111;
        pat[8]  = 7'b0000000; pat[9]  = 7'b0001100; pat[10] = 7'b0001000; pat[11] = 7'b1100000;
        pat[12] = 7'b0110001; pat[13] = 7'b1000010; pat[14] = 7'b0110000; pat[15] = 7'b0111000;
        model_reset();

        // Reset with a legal pattern already on the bus
        rst = 1'b1; clr = 1'b0;
        apply(4'b1110, 7'b0000001, 2);
        check("rst_hex", hex_out, 32'h0);
        check("rst_valid", digit_valid, 32'h0);
        check("rst_upd", upd, 32'h0);
        rst = 1'b0;
        upd_seen = 0;
        apply(4'b1110, 7'b0000001, 3);
        check("rst_no_early_upd", upd_seen, 32'd0);
        step();
        check("rst_first_upd", upd, 32'd1);
        check("rst_first_valid", digit_valid, 32'b0001);
        apply(4'b1110, 7'b0000001, 3);
        check("rst_single_upd", upd_seen, 32'd1);

        // Full decode table on digit 2
        upd_seen = 0;
        for (int k = 0; k < 16; k++) begin
            apply(4'b1011, pat[k], 6);
            check("sweep_nibble", hex_out[11:8], 32'(k));
        end
        check("sweep_upd_count", upd_seen, 32'd16);

        // Scan of all four digits, two rotations
        upd_seen = 0;
        for (int r = 0; r < 2; r++) begin
            apply(4'b1110, pat[3], 5);
            apply(4'b1101, pat[7], 5);
            apply(4'b1011, pat[10], 5);
            apply(4'b0111, pat[14], 5);
        end
        check("scan_hex", hex_out, 32'hEA73);
        check("scan_valid", digit_valid, 32'hF);
        check("scan_upd_count", upd_seen, 32'd8);

        // Glitch rejection on digit 0
        apply(4'b1110, 7'b0000000, 6);
        upd_seen = 0;
        apply(4'b1110, 7'b1001111, 2);
        apply(4'b1110, 7'b0000000, 2);
        check("glitch_no_upd", upd_seen, 32'd0);
        check("glitch_nibble", hex_out[3:0], 32'h8);
        apply(4'b1110, 7'b0000000, 4);
        check("glitch_return_upd", upd_seen, 32'd1);
        check("glitch_nibble_end", hex_out[3:0], 32'h8);

        // Blank, illegal, then legal again on digit 1
        apply(4'b1101, pat[5], 6);
        apply(4'b1101, 7'b1111111, 6);
        check("blank_flag", digit_blank[1], 32'd1);
        check("blank_valid", digit_valid[1], 32'd0);
        check("blank_nibble", hex_out[7:4], 32'h5);
        apply(4'b1101, 7'b1010101, 6);
        check("err_flag", digit_err[1], 32'd1);
        check("err_blank", digit_blank[1], 32'd0);
        apply(4'b1101, 7'b0110000, 6);
        check("recover_nibble", hex_out[7:4], 32'hE);
        check("recover_valid", digit_valid[1], 32'd1);
        check("recover_err", digit_err[1], 32'd0);

        // Multi-select, then clear during settle
        upd_seen = 0;
        apply(4'b1100, pat[2], 10);
        check("multi_no_upd", upd_seen, 32'd0);
        apply(4'b1110, pat[1], 2);
        clr = 1'b1;
        step();
        clr = 1'b0;
        apply(4'b1111, 7'b1111111, 4);
        check("clr_no_upd", upd_seen, 32'd0);
        check("clr_hex", hex_out, 32'h0);
        check("clr_valid", digit_valid, 32'h0);

        // Random dwells
        for (int d = 0; d < 300; d++) begin
            logic [ND-1:0] an;
            logic [6:0]    sg;
            int            r;
            r  = $urandom_range(0, 9);
            an = (r < 8) ? ~(ND'(1) << $urandom_range(0, ND - 1)) : ND'($urandom());
            r  = $urandom_range(0, 9);
            if (r < 7) sg = pat[$urandom_range(0, 15)];
            else if (r == 7) sg = 7'b1111111;
            else sg = 7'($urandom());
            clr = ($urandom_range(0, 19) == 0);
            apply(an, sg, $urandom_range(1, 7));
            clr = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seg_capture_decoder.md
Name: seg_capture_decoder

Overview:
- Receive-side counterpart of the hex-to-seven-segment encoder: watches a multiplexed, active-low seven-segment display bus (segments plus digit enables) and recovers the hex nibble shown on each digit.
- Debounces each digit dwell, decodes the segment pattern back to 4-bit hex, and holds one nibble register per digit.
- Flags blank and illegal patterns.
- Used as a display-readback monitor in the calculator datapath and as a self-check in system benches.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (1..8).
- STABLE_CYCLES, 4, consecutive identical samples required before capture (>=2).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- seg_n  input  7  segment bus {a,b,c,d,e,f,g}, a is MSB, active-low (0 = lit)
- an_n  input  NUM_DIGITS  digit enables, active-low, bit i selects digit i
- clr  input  1  synchronous clear of all captured state (same effect as rst)
- hex_out  output  4*NUM_DIGITS  captured nibbles, digit i in bits [4i+3:4i]
- digit_valid  output  NUM_DIGITS  digit i holds a successfully decoded nibble
- digit_blank  output  NUM_DIGITS  last capture for digit i was all-off (7'b1111111)
- digit_err  output  NUM_DIGITS  last capture for digit i was an illegal pattern
- upd  output  1  one-cycle pulse on every capture
- upd_idx  output  3  digit index of the capture; valid while upd=1

Behaviour:
- Reset (rst or clr, synchronous, rst wins if both):
  - hex_out=0, digit_valid=0, digit_blank=0, digit_err=0, upd=0, upd_idx=0.
  - Input sample register cleared to an_n all-ones, seg_n all-ones.
  - Stability counter cleared to 0; FSM goes to IDLE.
- Input stage: {an_n, seg_n} registered every clk into the sample register. All decisions use sampled values only.
- Stability counter:
  - Cleared to 0 when the new sample differs from the held sample.
  - Otherwise increments, saturating at STABLE_CYCLES-1.
- Selection rule: a sample is "single" iff exactly one bit of an_n is 0. Zero or multiple zeros count as no selection.
- FSM:
  - IDLE: waiting for a single selection. A single sample -> SETTLE.
  - SETTLE: sample is single and the counter is running.
    - Counter reaches STABLE_CYCLES-1 with the sample unchanged -> capture, then HOLD.
    - Sample changes to another single pattern -> stay in SETTLE (counter restarts).
    - Sample changes to a non-single pattern -> IDLE.
  - HOLD: captured; no further capture for this dwell.
    - Any sample change -> SETTLE if single, else IDLE.
    - The same pattern is not re-captured until it changes.
- Decode table (seg_n -> nibble), exact match only:
  - 0000001->0, 1001111->1, 0010010->2, 0000110->3
  - 1001100->4, 0100100->5, 0100000->6, 0001111->7
  - 0000000->8, 0001100->9, 0001000->A, 1100000->B
  - 0110001->C, 1000010->D, 0110000->E, 0111000->F
- Capture effect on digit i:
  - Legal pattern: nibble written, valid=1, blank=0, err=0.
  - 1111111: nibble unchanged, valid=0, blank=1, err=0.
  - Any other pattern: nibble unchanged, valid=0, blank=0, err=1.
  - Other digits are unaffected in every case.
- Timing: with the pair applied before edge t0 and held, the capture takes effect at edge t0+STABLE_CYCLES-1. Outputs are registered and visible after that edge; upd=1 and upd_idx=i for exactly that one cycle.
- Glitch rejection: a segment change within a dwell shorter than STABLE_CYCLES samples produces no capture of the transient pattern.
- Reset mid-SETTLE: the pending capture is abandoned with no upd pulse.
- upd_idx: width fixed at 3; upper bits are 0 when NUM_DIGITS<8.

Test Plan:
- Reset: drive rst 2 cycles with an_n=1110, seg_n=0000001 -> all outputs 0. After release with inputs held, hex_out[3:0]=0, digit_valid=0001 and upd pulses once, 3 edges after the first sample (STABLE_CYCLES=4).
- Full table sweep: for digit 2 (an_n=1011), apply each of the 16 legal patterns for 6 cycles each -> hex_out[11:8] steps 0..F, digit_valid[2]=1 throughout, exactly 16 upd pulses with upd_idx=2.
- Scan: rotate an_n 1110,1101,1011,0111 with patterns for 3,7,A,E, 5 cycles per dwell, two full rotations -> hex_out=16'hEA73, digit_valid=1111, one upd per dwell.
- Glitch: digit 0 shows 8 (0000000); toggle seg_n to 1001111 for 2 cycles, then back -> no capture of 1; nibble stays 8; upd pulses only after the return is stable 4 samples.
- Errors/blank: digit 1 shows 5, then 1111111 for 6 cycles -> blank[1]=1, valid[1]=0, nibble stays 5. Then 1010101 -> err[1]=1, blank[1]=0. Then 0110000 -> nibble=E, valid=1, err=0.
- Multi-select and reset mid-settle: an_n=1100 held 10 cycles -> no upd. Then an_n=1110 for 2 cycles followed by clr -> no upd and all outputs 0.
